// File: rtl/mem_arbiter.sv
// Shared memory bus arbiter between instruction fetch and data load/store ports.
// One requester is granted at a time. Conflicts resolve round-robin. Each access runs a
// read/write handshake on the bus and ends with a registered one-cycle ready pulse.
// A watchdog aborts accesses that stay busy for TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        i_ready,
    output logic [31:0] i_instr,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        stall,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_ren,
    output logic        bus_wen,
    input  logic        bus_busy,
    input  logic [31:0] bus_rdata
);

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIAcc, StDAcc, StResp} state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              gnt_data_q, gnt_data_d;   // current access belongs to the data port
    logic              last_data_q, last_data_d; // most recent grant went to the data port
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   cnt_inc;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              d_pend;
    logic              pick_data;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b1;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state: arbitration in idle, handshake and watchdog during an access.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        d_pend      = d_read | d_write;
        // Saturating increment; the counter must never wrap back to zero.
        cnt_inc     = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        // On a conflict the port that did not win last time gets the bus.
        pick_data   = d_pend & (~i_req | ~last_data_q);

        unique case (state_q)
            StIdle: begin
                if (i_req || d_pend) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    cnt_d       = '0;
                    if (pick_data) begin
                        addr_d  = d_addr;
                        write_d = d_write;
                        wdata_d = d_write ? d_wdata : 32'h0;
                        state_d = StDAcc;
                    end else begin
                        addr_d  = i_addr;
                        write_d = 1'b0;
                        wdata_d = 32'h0;
                        state_d = StIAcc;
                    end
                end
            end
            StIAcc, StDAcc: begin
                if (!bus_busy) begin
                    rdata_d = write_q ? 32'h0 : bus_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (32'(cnt_inc) == TIMEOUT)) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus strobes and requester responses decoded from the registered state.
    always_comb begin
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        bus_ren   = ((state_q == StIAcc) || (state_q == StDAcc)) & ~write_q;
        bus_wen   = ((state_q == StIAcc) || (state_q == StDAcc)) & write_q;
        i_ready   = (state_q == StResp) & ~gnt_data_q;
        d_ready   = (state_q == StResp) & gnt_data_q;
        i_instr   = i_ready ? rdata_q : 32'h0;
        d_rdata   = d_ready ? rdata_q : 32'h0;
        err       = (state_q == StResp) & err_q;
        stall     = (i_req & ~i_ready) | ((d_read | d_write) & ~d_ready);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, a transaction-level model checked every cycle,
// and literal expectations at hand-computed cycles.
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_ready;
    logic [31:0] i_instr;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        err;
    logic        stall;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ren;
    logic        bus_wen;
    logic        bus_busy;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory contents: word 0 holds an addi opcode, everything else is address-tagged.
    assign bus_rdata = (bus_addr == 32'h0) ? 32'h0000_0093 : (bus_addr ^ 32'hC0DE_0000);

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .i_ready   (i_ready),
        .i_instr   (i_instr),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .err       (err),
        .stall     (stall),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_busy  (bus_busy),
        .bus_rdata (bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the transaction in flight, whether its answer is due, and who was served last.
    bit          m_on_bus   = 1'b0;
    bit          m_answer   = 1'b0;
    bit          m_is_data  = 1'b0;
    bit          m_is_write = 1'b0;
    bit          m_last_dat = 1'b1;
    logic [31:0] m_addr     = 32'h0;
    logic [31:0] m_wdata    = 32'h0;
    logic [31:0] m_result   = 32'h0;
    bit          m_abort    = 1'b0;
    int          m_waits    = 0;

    // Compare DUT against the model mid-cycle, then account for what the next edge does.
    always @(negedge clk) begin
        logic exp_ir;
        logic exp_dr;
        bit   want_i;
        bit   want_d;
        bit   serve_d;
        exp_ir = m_answer & ~m_is_data;
        exp_dr = m_answer & m_is_data;
        check("bus_ren", {31'b0, bus_ren}, {31'b0, m_on_bus & ~m_is_write});
        check("bus_wen", {31'b0, bus_wen}, {31'b0, m_on_bus & m_is_write});
        check("i_ready", {31'b0, i_ready}, {31'b0, exp_ir});
        check("d_ready", {31'b0, d_ready}, {31'b0, exp_dr});
        check("stall", {31'b0, stall},
              {31'b0, (i_req & ~exp_ir) | ((d_read | d_write) & ~exp_dr)});
        if (m_on_bus) check("bus_addr", bus_addr, m_addr);
        if (m_on_bus && m_is_write) check("bus_wdata", bus_wdata, m_wdata);
        if (exp_ir) check("i_instr", i_instr, m_result);
        if (exp_dr) check("d_rdata", d_rdata, m_result);
        if (m_answer) check("err", {31'b0, err}, {31'b0, m_abort});

        if (rst) begin
            m_on_bus   = 1'b0;
            m_answer   = 1'b0;
            m_last_dat = 1'b1;
        end else if (m_answer) begin
            m_answer = 1'b0;
        end else if (m_on_bus) begin
            if (!bus_busy) begin
                m_result = m_is_write ? 32'h0 : bus_rdata;
                m_abort  = 1'b0;
                m_on_bus = 1'b0;
                m_answer = 1'b1;
            end else begin
                m_waits++;
                if (TIMEOUT != 0 && m_waits >= int'(TIMEOUT)) begin
                    m_result = 32'h0;
                    m_abort  = 1'b1;
                    m_on_bus = 1'b0;
                    m_answer = 1'b1;
                end
            end
        end else begin
            want_i = i_req;
            want_d = d_read | d_write;
            if (want_i && want_d) serve_d = !m_last_dat;
            else serve_d = want_d;
            if (want_i || want_d) begin
                m_on_bus   = 1'b1;
                m_waits    = 0;
                m_is_data  = serve_d;
                m_last_dat = serve_d;
                if (serve_d) begin
                    m_addr     = d_addr;
                    m_is_write = d_write;
                    m_wdata    = d_wdata;
                end else begin
                    m_addr     = i_addr;
                    m_is_write = 1'b0;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    initial begin
        int   ren_cnt;
        int   wen_cnt;
        logic ir_seen [12];
        logic dr_seen [12];

        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; bus_busy = 1'b0;
        next_cycle();
        next_cycle();

        // Fetch with zero wait states.
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h0;
        mid_cycle();
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_i_instr", i_instr, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h1);
        next_cycle(); mid_cycle();
        check("f1_ren", {31'b0, bus_ren}, 32'h1);
        check("f1_addr", bus_addr, 32'h0);
        next_cycle(); mid_cycle();
        check("f2_iready", {31'b0, i_ready}, 32'h1);
        check("f2_instr", i_instr, 32'h0000_0093);
        check("f2_err", {31'b0, err}, 32'h0);
        check("f2_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        i_req = 1'b0;

        // Store with three busy cycles.
        d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; bus_busy = 1'b1;
        mid_cycle();
        ren_cnt = 0; wen_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c == 4) bus_busy = 1'b0;
            mid_cycle();
            wen_cnt += int'(bus_wen);
            ren_cnt += int'(bus_ren);
            if (c == 5) begin
                check("st_dready", {31'b0, d_ready}, 32'h1);
                check("st_rdata", d_rdata, 32'h0);
                check("st_err", {31'b0, err}, 32'h0);
            end
        end
        check("st_wen_cycles", wen_cnt, 32'd4);
        check("st_ren_cycles", ren_cnt, 32'd0);
        next_cycle();
        d_write = 1'b0;

        // Fetch and load both held from reset: grants alternate starting with fetch.
        rst = 1'b1; i_req = 1'b1; d_read = 1'b1; i_addr = 32'h40; d_addr = 32'h80;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cycle();
            mid_cycle();
            ir_seen[c] = i_ready;
            dr_seen[c] = d_ready;
            if (c == 2) check("rr_instr", i_instr, 32'hC0DE_0040);
            if (c == 5) check("rr_rdata", d_rdata, 32'hC0DE_0080);
        end
        check("rr_i2", {31'b0, ir_seen[2]}, 32'h1);
        check("rr_d2", {31'b0, dr_seen[2]}, 32'h0);
        check("rr_d5", {31'b0, dr_seen[5]}, 32'h1);
        check("rr_i5", {31'b0, ir_seen[5]}, 32'h0);
        check("rr_i8", {31'b0, ir_seen[8]}, 32'h1);
        check("rr_d11", {31'b0, dr_seen[11]}, 32'h1);
        next_cycle();
        i_req = 1'b0; d_read = 1'b0;
        next_cycle();

        // Load against a bus stuck busy: watchdog abort.
        d_read = 1'b1; d_addr = 32'h200; bus_busy = 1'b1;
        mid_cycle();
        ren_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); mid_cycle();
            ren_cnt += int'(bus_ren);
            if (c == 5) begin
                check("to_dready", {31'b0, d_ready}, 32'h1);
                check("to_err", {31'b0, err}, 32'h1);
                check("to_rdata", d_rdata, 32'h0);
                check("to_ren_resp", {31'b0, bus_ren}, 32'h0);
            end
        end
        check("to_ren_cycles", ren_cnt, 32'd4);
        next_cycle();
        d_read = 1'b0; bus_busy = 1'b0;
        next_cycle();

        // Load and store together: the store wins.
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234_5678;
        mid_cycle();
        next_cycle(); mid_cycle();
        check("rw_wen", {31'b0, bus_wen}, 32'h1);
        check("rw_ren", {31'b0, bus_ren}, 32'h0);
        check("rw_wdata", bus_wdata, 32'h1234_5678);
        next_cycle(); mid_cycle();
        check("rw_dready", {31'b0, d_ready}, 32'h1);
        check("rw_rdata", d_rdata, 32'h0);
        next_cycle();
        d_read = 1'b0; d_write = 1'b0;
        next_cycle();

        // Reset in the middle of a load, then the held request completes.
        d_read = 1'b1; d_addr = 32'h400; bus_busy = 1'b1;
        mid_cycle();
        next_cycle(); mid_cycle();
        check("ra_ren1", {31'b0, bus_ren}, 32'h1);
        next_cycle();
        rst = 1'b1;
        mid_cycle();
        next_cycle();
        rst = 1'b0; bus_busy = 1'b0;
        mid_cycle();
        check("ra_ren_after", {31'b0, bus_ren}, 32'h0);
        check("ra_dready_after", {31'b0, d_ready}, 32'h0);
        next_cycle(); mid_cycle();
        check("ra_ren_retry", {31'b0, bus_ren}, 32'h1);
        check("ra_dready_retry", {31'b0, d_ready}, 32'h0);
        next_cycle(); mid_cycle();
        check("ra_dready_done", {31'b0, d_ready}, 32'h1);
        check("ra_rdata", d_rdata, 32'hC0DE_0400);
        next_cycle();
        d_read = 1'b0;
        repeat (3) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
